// File: rtl/audio_pkg.sv
// Shared types and constants for the I2S transmitter.
// Contents: sample and frame widths, divider and slot counter widths,
// the controller state enum and the stereo pair payload struct.
package audio_pkg;

  localparam int unsigned SAMPLE_W   = 16;
  localparam int unsigned FRAME_BITS = 32;
  localparam int unsigned SLOT_W     = $clog2(FRAME_BITS);
  localparam int unsigned DIV_W      = 8;
  localparam int unsigned UCNT_W     = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Left sample occupies the upper half so {l, r} matches the wire order.
  typedef struct packed {
    logic [SAMPLE_W-1:0] l;
    logic [SAMPLE_W-1:0] r;
  } pair_t;

endpackage

// File: rtl/i2s_clkgen.sv
// Bit-clock generator: divides clkin down to BCLK and counts frame slots.
// Ports:
//   clkin, reset   - clock and synchronous active-high reset
//   bclk           - bit clock, toggles every BCLK_DIV clkin cycles
//   fall_c         - one-cycle strobe on the cycle bclk toggles 1->0
//   bit_cnt        - current slot within the 32-slot frame
module i2s_clkgen
  import audio_pkg::*;
#(
  parameter int unsigned BCLK_DIV = 9
) (
  input  logic              clkin,
  input  logic              reset,
  output logic              bclk,
  output logic              fall_c,
  output logic [SLOT_W-1:0] bit_cnt
);

  logic [DIV_W-1:0] div_cnt;
  logic             div_wrap_c;

  assign div_wrap_c = (div_cnt == DIV_W'(BCLK_DIV - 1));
  // bclk is about to drop: this is the only cycle slot state may change.
  assign fall_c     = div_wrap_c && bclk;

  // Divider, bit clock and slot counter.
  always_ff @(posedge clkin) begin
    if (reset) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      bit_cnt <= '0;
    end else begin
      div_cnt <= div_wrap_c ? '0 : div_cnt + DIV_W'(1);
      if (div_wrap_c) begin
        bclk <= ~bclk;
      end
      if (fall_c) begin
        bit_cnt <= bit_cnt + SLOT_W'(1);
      end
    end
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// Philips-format I2S transmitter with a one-pair holding register.
// Ports:
//   clkin, reset            - clock and synchronous active-high reset
//   sample_l, sample_r      - stereo PCM pair, two's complement
//   sample_valid/ready      - pair handshake, accepted when both high
//   i2s_bclk/lrclk/sdata    - serial audio outputs, MSB first
//   underrun                - one-cycle pulse when a frame starts with no data
//   underrun_cnt            - saturating underrun count, only present when
//                             I2S_UNDERRUN_CNT_EN is defined
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int unsigned BCLK_DIV = 9
) (
  input  logic                clkin,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample_l,
  input  logic [SAMPLE_W-1:0] sample_r,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                i2s_bclk,
  output logic                i2s_lrclk,
  output logic                i2s_sdata,
  output logic                underrun
`ifdef I2S_UNDERRUN_CNT_EN
  ,
  output logic [UCNT_W-1:0]   underrun_cnt
`endif
);

  state_t                state_q;
  state_t                state_d;
  pair_t                 hold_q;
  logic                  hold_full_q;
  logic [FRAME_BITS-1:0] sreg_q;
  logic                  underrun_q;
  logic                  fall_c;
  logic [SLOT_W-1:0]     bit_cnt;
  logic                  accept_c;
  logic                  load_c;
  logic                  started_c;

  i2s_clkgen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_clkgen (
    .clkin   (clkin),
    .reset   (reset),
    .bclk    (i2s_bclk),
    .fall_c  (fall_c),
    .bit_cnt (bit_cnt)
  );

  assign sample_ready = !hold_full_q && !reset;
  assign accept_c     = sample_valid && sample_ready;
  // Load on the fall where the slot counter steps 0 -> 1.
  assign load_c       = fall_c && (bit_cnt == SLOT_W'(0));
  assign started_c    = (state_q == RUN);

  assign i2s_sdata    = sreg_q[FRAME_BITS-1];
  assign i2s_lrclk    = bit_cnt[SLOT_W-1];
  assign underrun     = underrun_q;

  // State register.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave IDLE on the first accepted pair, only reset returns.
  always_comb begin
    state_d = state_q;
    if ((state_q == IDLE) && accept_c) begin
      state_d = RUN;
    end
  end

  // Shifter, holding register and underrun pulse.
  always_ff @(posedge clkin) begin
    if (reset) begin
      sreg_q      <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      underrun_q <= 1'b0;
      if (load_c) begin
        if (hold_full_q) begin
          sreg_q      <= hold_q;
          hold_full_q <= 1'b0;
        end else begin
          sreg_q     <= '0;
          underrun_q <= started_c;
        end
      end else if (fall_c) begin
        sreg_q <= {sreg_q[FRAME_BITS-2:0], 1'b0};
      end
      // Accept is only possible with the hold empty, so it never races a
      // hold->sreg transfer; a same-cycle empty load still keeps the pair.
      if (accept_c) begin
        hold_q      <= '{l: sample_l, r: sample_r};
        hold_full_q <= 1'b1;
      end
    end
  end

`ifdef I2S_UNDERRUN_CNT_EN
  // Saturating underrun counter.
  always_ff @(posedge clkin) begin
    if (reset) begin
      underrun_cnt <= '0;
    end else if (underrun_q && (underrun_cnt != {UCNT_W{1'b1}})) begin
      underrun_cnt <= underrun_cnt + UCNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/audio_i2s_tx.md
AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 SHALL have parameter BCLK_DIV, default 9: clkin cycles per BCLK half-period, legal range 2..255. With clkin = 27 MHz this gives BCLK = 1.5 MHz and fs = 46.875 kHz.
REQ-002 SHALL have clkin, input, 1: single clock, driven by the PLL clkout.
REQ-003 SHALL have reset, input, 1: synchronous active-high reset.
REQ-004 SHALL have sample_l, input, 16: left PCM sample, two's complement.
REQ-005 SHALL have sample_r, input, 16: right PCM sample, two's complement.
REQ-006 SHALL have sample_valid, input, 1: stereo pair offered.
REQ-007 SHALL have sample_ready, output, 1: pair accepted on the cycle where valid and ready are both high.
REQ-008 SHALL have i2s_bclk, output, 1: bit clock.
REQ-009 SHALL have i2s_lrclk, output, 1: word select; 0 means left, 1 means right.
REQ-010 SHALL have i2s_sdata, output, 1: serial data, MSB first.
REQ-011 SHALL have underrun, output, 1: one-cycle pulse.

Function
REQ-012 Divider: div_cnt SHALL count 0..BCLK_DIV-1 and wrap. i2s_bclk SHALL toggle on the cycle div_cnt == BCLK_DIV-1.
REQ-013 "Fall event": the cycle on which i2s_bclk toggles 1->0. All lrclk, sdata and bit_cnt updates SHALL occur only on fall events.
REQ-014 bit_cnt SHALL be 5 bits, increment on each fall event, and wrap 31->0.
REQ-015 i2s_lrclk SHALL be 1 while bit_cnt is 16..31 and 0 while it is 0..15.
REQ-016 Shifter: a 32-bit sreg SHALL drive i2s_sdata = sreg[31].
- On the fall event where bit_cnt becomes 1 ("load"), sreg SHALL load {L, R}.
- On every other fall event, sreg SHALL shift left, filling with 0.
- This gives Philips timing: L MSB in slot 1, R MSB in slot 17, R LSB in slot 0 of the next frame.
REQ-017 Holding register: hold_l, hold_r and hold_full SHALL implement it. sample_ready SHALL equal !hold_full && !reset.
REQ-018 Accept: hold_full SHALL set on the cycle after valid && ready.
REQ-019 Load with hold_full = 1: sreg SHALL take the hold contents and hold_full SHALL clear on the same cycle.
REQ-020 Load with hold_full = 0: sreg SHALL load 32'h0. If a pair has been accepted since reset (started = 1), underrun SHALL pulse high for that one cycle.
REQ-021 Accept and load on the same cycle with the hold empty: sreg SHALL load zeros and the accepted pair SHALL enter hold. No data SHALL be lost.
REQ-022 A sample pair SHALL reach i2s_sdata no later than 32 BCLK periods plus 1 clkin cycle after acceptance.
REQ-023 State machine: IDLE -> RUN on the first accept; RUN -> IDLE only on reset.
- IDLE: shifter outputs zeros and underrun is suppressed.
- The BCLK and LRCLK clocks SHALL run in both states.

Reset
REQ-024 While reset is high, the following SHALL be 0: i2s_bclk, i2s_lrclk, i2s_sdata, underrun, sample_ready, div_cnt, bit_cnt, sreg, hold_full, started. State SHALL be IDLE.
REQ-025 Reset asserted mid-frame SHALL abort the frame and discard hold contents.
- The first fall event after reset SHALL occur 2*BCLK_DIV cycles after deassertion, with bit_cnt becoming 1.

Configuration
REQ-026 With I2S_UNDERRUN_CNT_EN defined:
- The block SHALL add an output underrun_cnt, 16 bits.
- underrun_cnt SHALL be 0 on reset, increment on each underrun pulse, and saturate at 16'hFFFF.
REQ-027 Without I2S_UNDERRUN_CNT_EN: the port and counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 Package audio_pkg SHALL hold:
- SAMPLE_W = 16
- FRAME_BITS = 32
- state enum {IDLE, RUN}
REQ-029 Sub-module i2s_clkgen SHALL contain div_cnt, i2s_bclk, the fall-event strobe and bit_cnt. audio_i2s_tx SHALL instantiate it once.

Verification
REQ-030 Reset release with BCLK_DIV = 9 -> i2s_bclk period 18 cycles; i2s_lrclk period 576 cycles; sdata = 0; underrun never pulses.
REQ-031 Offer L = 16'hA5C3 and R = 16'h0F01 before a load -> slots 1..16 serialize A5C3 MSB-first, slots 17..31 plus next slot 0 serialize 0F01. Sample sdata on the BCLK rising edge.
REQ-032 Hold valid continuously with incrementing pairs -> sample_ready pulses once per 576 cycles; no underrun; every pair appears in order.
REQ-033 Stop offering after one pair -> at the next load, sdata frame is all-zero and underrun pulses exactly 1 cycle. With I2S_UNDERRUN_CNT_EN, underrun_cnt = 1.
REQ-034 Assert valid on exactly the load cycle with hold empty -> zeros frame plus underrun pulse; the pair is output in the following frame.
REQ-035 Assert reset in slot 20 with hold full -> outputs 0 next cycle; after release, the pair is not emitted and no underrun pulses.
